// File: rtl/arm_position_tracker_if.sv
// Uniboard register bus for one position tracker. The two tri-state nets are
// resolved here from the slave read path and the host write path.
interface arm_position_tracker_if;
  wire  [31:0] databus;
  wire  [2:0]  reg_size;
  logic [7:0]  register_addr;
  logic        rw;
  logic        select;
  logic [31:0] read_data;
  logic [2:0]  read_size;
  logic        data_oe;
  logic        size_oe;
  logic [31:0] write_data;
  logic        host_oe;

  // Both tri-state nets have a single driver each, so the two sides never contend.
  assign databus  = data_oe ? read_data : (host_oe ? write_data : 'z);
  assign reg_size = size_oe ? read_size : 'z;

  modport slave (
    input  databus, register_addr, rw, select,
    output read_data, read_size, data_oe, size_oe
  );

  modport master (
    input  databus, reg_size, data_oe, size_oe,
    output register_addr, rw, select, write_data, host_oe
  );
endinterface

// File: rtl/arm_position_tracker.sv
// Absolute step position tracker for one arm axis: counts step/dir, homes on a
// limit press, and raises pause_out when the soft travel limits are reached.
module arm_position_tracker #(
  parameter logic [7:0] pos_haddr = 8'h40
) (
  input  logic                        clk_12MHz,
  input  logic                        reset,
  arm_position_tracker_if.slave       bus,
  input  logic                        step_line,
  input  logic                        dir,
  input  logic                        step_pol,
  input  logic                        limitn,
  output logic                        pause_out
);

  typedef enum logic [7:0] {
    OFS_CTRL   = 8'd0,
    OFS_STATUS = 8'd1,
    OFS_POS    = 8'd2,
    OFS_MIN    = 8'd3,
    OFS_MAX    = 8'd4
  } reg_ofs_e;

  logic [1:0]  control;
  logic [31:0] position;
  logic [31:0] min_limit;
  logic [31:0] max_limit;
  logic        homed;
  logic        overflow;
  logic        at_min;
  logic        at_max;
  logic [31:0] read_value;
  logic [2:0]  read_size;
  logic        prev_select;

  logic step_s1, step_sync, step_prev;
  logic dir_s1, dir_sync;
  logic lim_s1, lim_sync, lim_prev;

  logic [7:0]  offset;
  logic [31:0] rd_value;
  logic [2:0]  rd_size;
  logic        sel_rise, wr;
  logic        step_evt, home_evt, wrap;
  logic        min_hit, max_hit;
  logic [31:0] step_next;

  assign offset   = bus.register_addr - pos_haddr;
  assign sel_rise = bus.select & ~prev_select;
  assign wr       = sel_rise & ~bus.rw;

  // Edge chosen on the synchronised line itself, so changing step_pol or
  // leaving reset with the line idle high never fabricates a step.
  assign step_evt  = step_pol ? (step_sync & ~step_prev) : (~step_sync & step_prev);
  assign home_evt  = control[1] & ~lim_sync & lim_prev;
  assign step_next = dir_sync ? position + 32'd1 : position - 32'd1;
  assign wrap      = dir_sync ? (position == 32'h7FFF_FFFF) : (position == 32'h8000_0000);
  assign min_hit   = $signed(position) <= $signed(min_limit);
  assign max_hit   = $signed(position) >= $signed(max_limit);

  always_comb begin
    rd_value = '0;
    rd_size  = '0;
    case (offset)
      OFS_CTRL:   begin rd_value = {30'd0, control}; rd_size = 3'd1; end
      OFS_STATUS: begin rd_value = {28'd0, overflow, homed, at_max, at_min}; rd_size = 3'd1; end
      OFS_POS:    begin rd_value = position;  rd_size = 3'd4; end
      OFS_MIN:    begin rd_value = min_limit; rd_size = 3'd4; end
      OFS_MAX:    begin rd_value = max_limit; rd_size = 3'd4; end
      default:    begin rd_value = '0; rd_size = '0; end
    endcase
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      control     <= '0;
      position    <= '0;
      min_limit   <= 32'h8000_0000;
      max_limit   <= 32'h7FFF_FFFF;
      homed       <= 1'b0;
      overflow    <= 1'b0;
      at_min      <= 1'b0;
      at_max      <= 1'b0;
      pause_out   <= 1'b0;
      read_value  <= '0;
      read_size   <= '0;
      prev_select <= 1'b0;
      step_s1     <= 1'b0;
      step_sync   <= 1'b0;
      step_prev   <= 1'b0;
      dir_s1      <= 1'b0;
      dir_sync    <= 1'b0;
      lim_s1      <= 1'b0;
      lim_sync    <= 1'b0;
      lim_prev    <= 1'b0;
    end else begin
      prev_select <= bus.select;
      step_s1     <= step_line;
      step_sync   <= step_s1;
      step_prev   <= step_sync;
      dir_s1      <= dir;
      dir_sync    <= dir_s1;
      lim_s1      <= limitn;
      lim_sync    <= lim_s1;
      lim_prev    <= lim_sync;

      if (sel_rise) begin
        read_value <= rd_value;
        read_size  <= rd_size;
      end
      if (wr && offset == OFS_CTRL)   control   <= bus.databus[1:0];
      if (wr && offset == OFS_MIN)    min_limit <= bus.databus;
      if (wr && offset == OFS_MAX)    max_limit <= bus.databus;
      if (wr && offset == OFS_STATUS) begin
        overflow <= 1'b0;
        homed    <= 1'b0;
      end

      // Single priority chain: a step coinciding with any other update is lost.
      if (wr && offset == OFS_POS) begin
        position <= bus.databus;
      end else if (wr && offset == OFS_CTRL && bus.databus[2]) begin
        position <= '0;
      end else if (home_evt) begin
        position <= '0;
        homed    <= 1'b1;
      end else if (step_evt) begin
        position <= step_next;
        if (wrap) overflow <= 1'b1;
      end

      at_min    <= min_hit;
      at_max    <= max_hit;
      pause_out <= control[0] & ((dir_sync & max_hit) | (~dir_sync & min_hit));
    end
  end

  assign bus.read_data = read_value;
  assign bus.read_size = read_size;
  assign bus.data_oe   = bus.select & bus.rw;
  assign bus.size_oe   = bus.select;

endmodule

// File: tb/tb_arm_position_tracker.sv
// Scoreboard bench for arm_position_tracker: bus reads push expectations, a
// monitor pops and compares when read data becomes valid on the bus.
module tb_arm_position_tracker;
  logic clk = 1'b0;
  logic reset;
  logic step_line, dir, step_pol, limitn;
  logic pause_out;

  arm_position_tracker_if bif ();

  arm_position_tracker #(.pos_haddr(8'h40)) dut (
    .clk_12MHz (clk),
    .reset     (reset),
    .bus       (bif),
    .step_line (step_line),
    .dir       (dir),
    .step_pol  (step_pol),
    .limitn    (limitn),
    .pause_out (pause_out)
  );

  always #41 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [2:0]  size;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bif.register_addr = addr;
    bif.rw            = 1'b0;
    bif.write_data    = data;
    bif.host_oe       = 1'b1;
    bif.select        = 1'b1;
    @(posedge clk); #1;
    bif.select  = 1'b0;
    bif.host_oe = 1'b0;
    cycles(1);
  endtask

  task automatic bus_read(input logic [7:0] addr, input string name,
                          input logic [31:0] exp, input logic [2:0] size);
    exp_t e;
    e.name = name; e.data = exp; e.size = size;
    sb.push_back(e);
    @(posedge clk); #1;
    bif.register_addr = addr;
    bif.rw            = 1'b1;
    bif.select        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bif.select = 1'b0;
    bif.rw     = 1'b0;
    cycles(1);
  endtask

  // One full pulse away from and back to the idle level; counts once for either polarity.
  task automatic step_pulse(input logic d);
    dir = d;
    cycles(3);
    step_line = ~step_line;
    cycles(3);
    step_line = ~step_line;
    cycles(3);
  endtask

  // Monitor: read data is valid on the falling edge after the select rise is clocked.
  initial begin : monitor
    logic sel_q;
    exp_t e;
    sel_q = 1'b0;
    forever begin
      @(posedge clk);
      if (bif.select && bif.rw && !sel_q) begin
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got data %h size %0d with no expectation queued",
                   bif.databus, bif.reg_size);
        end else begin
          e = sb.pop_front();
          if (bif.databus !== e.data || bif.reg_size !== e.size) begin
            errors++;
            $display("FAIL %s: got data %h size %0d expected data %h size %0d",
                     e.name, bif.databus, bif.reg_size, e.data, e.size);
          end
        end
      end
      sel_q = bif.select;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    step_line = 1'b0; dir = 1'b0; step_pol = 1'b1; limitn = 1'b1;
    bif.register_addr = '0; bif.rw = 1'b0; bif.select = 1'b0;
    bif.write_data = '0; bif.host_oe = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(4);

    check("reset_pause", {31'd0, pause_out}, 32'd0);
    check("idle_data_oe", {31'd0, bif.data_oe}, 32'd0);
    check("idle_size_oe", {31'd0, bif.size_oe}, 32'd0);
    bus_read(8'h40, "reset_control", 32'h0000_0000, 3'd1);
    bus_read(8'h41, "reset_status",  32'h0000_0000, 3'd1);
    bus_read(8'h42, "reset_position", 32'h0000_0000, 3'd4);
    bus_read(8'h43, "reset_min", 32'h8000_0000, 3'd4);
    bus_read(8'h44, "reset_max", 32'h7FFF_FFFF, 3'd4);

    // Rising-edge counting both directions.
    for (int i = 0; i < 5; i++) step_pulse(1'b1);
    bus_read(8'h42, "count_up_5", 32'd5, 3'd4);
    for (int i = 0; i < 7; i++) step_pulse(1'b0);
    bus_read(8'h42, "count_down_to_m2", 32'hFFFF_FFFE, 3'd4);

    // Falling-edge polarity: the idle-high rise must not count.
    step_pol = 1'b0;
    cycles(2);
    step_line = 1'b1;
    cycles(5);
    bus_read(8'h42, "pol0_rise_ignored", 32'hFFFF_FFFE, 3'd4);
    step_pulse(1'b1);
    step_pulse(1'b1);
    bus_read(8'h42, "pol0_two_falls", 32'd0, 3'd4);
    cycles(2);
    step_line = 1'b0;
    cycles(1);
    step_line = 1'b1;
    cycles(5);
    bus_read(8'h42, "pol0_one_clock_pulse", 32'd1, 3'd4);
    step_pol = 1'b1;
    cycles(2);
    step_line = 1'b0;
    cycles(5);
    bus_read(8'h42, "pol1_fall_ignored", 32'd1, 3'd4);

    // Overflow wrap and sticky flag.
    bus_write(8'h42, 32'h7FFF_FFFF);
    step_pulse(1'b1);
    bus_read(8'h42, "wrap_position", 32'h8000_0000, 3'd4);
    bus_read(8'h41, "wrap_status", 32'h0000_0009, 3'd1);
    bus_write(8'h41, 32'h0000_0000);
    bus_read(8'h41, "status_cleared", 32'h0000_0001, 3'd1);

    // Soft max limit with exact pause timing.
    bus_write(8'h44, 32'd10);
    bus_write(8'h42, 32'd8);
    bus_write(8'h40, 32'h0000_0001);
    step_pulse(1'b1);
    cycles(2);
    check("pause_below_max", {31'd0, pause_out}, 32'd0);
    @(posedge clk); #1;
    step_line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pause_same_clock_as_pos", {31'd0, pause_out}, 32'd0);
    @(negedge clk);
    check("pause_at_max", {31'd0, pause_out}, 32'd1);
    cycles(2);
    step_line = 1'b0;
    cycles(3);
    bus_read(8'h41, "status_at_max", 32'h0000_0002, 3'd1);
    @(posedge clk); #1;
    dir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pause_before_dir_sync", {31'd0, pause_out}, 32'd1);
    @(negedge clk);
    check("pause_released_on_reverse", {31'd0, pause_out}, 32'd0);

    // Homing enabled, then disabled.
    bus_write(8'h44, 32'h7FFF_FFFF);
    bus_write(8'h40, 32'h0000_0002);
    bus_write(8'h42, 32'd123);
    limitn = 1'b0;
    cycles(5);
    limitn = 1'b1;
    cycles(4);
    bus_read(8'h42, "homed_position", 32'd0, 3'd4);
    bus_read(8'h41, "homed_status", 32'h0000_0004, 3'd1);
    bus_write(8'h41, 32'h0000_00FF);
    bus_read(8'h41, "homed_cleared", 32'h0000_0000, 3'd1);
    bus_write(8'h40, 32'h0000_0000);
    bus_write(8'h42, 32'd123);
    limitn = 1'b0;
    cycles(5);
    limitn = 1'b1;
    cycles(4);
    bus_read(8'h42, "home_disabled", 32'd123, 3'd4);

    // Step event lands in the same clock as a Position write.
    dir = 1'b1;
    cycles(3);
    @(posedge clk); #1;
    step_line = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    bif.register_addr = 8'h42; bif.rw = 1'b0; bif.write_data = 32'd50;
    bif.host_oe = 1'b1; bif.select = 1'b1;
    @(posedge clk); #1;
    bif.select = 1'b0; bif.host_oe = 1'b0;
    cycles(3);
    step_line = 1'b0;
    cycles(3);
    bus_read(8'h42, "write_beats_step", 32'd50, 3'd4);

    // Control bit2 clears position and is not stored.
    bus_write(8'h40, 32'h0000_0007);
    bus_read(8'h40, "control_bit2_not_stored", 32'h0000_0003, 3'd1);
    bus_read(8'h42, "control_clear_position", 32'd0, 3'd4);
    bus_write(8'h40, 32'h0000_0000);

    // Unmapped addresses on both sides of the window.
    bus_read(8'h45, "unmapped_above", 32'd0, 3'd0);
    bus_read(8'h3F, "unmapped_below", 32'd0, 3'd0);
    check("deselect_data_oe", {31'd0, bif.data_oe}, 32'd0);
    check("deselect_size_oe", {31'd0, bif.size_oe}, 32'd0);

    // Reset mid-operation restores limits and position.
    bus_write(8'h43, 32'd5);
    bus_write(8'h42, 32'd77);
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(4);
    bus_read(8'h43, "reset_mid_min", 32'h8000_0000, 3'd4);
    bus_read(8'h42, "reset_mid_position", 32'd0, 3'd4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) cycles(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
